// File: rtl/audio_pkg.sv
// rtl/audio_pkg.sv - format codes, timer states and parameter legality check for the audio transmitters
package audio_pkg;

    localparam logic [1:0] FMT_I2S = 2'd0;
    localparam logic [1:0] FMT_LJ  = 2'd1;
    localparam logic [1:0] FMT_DSP = 2'd2;

    typedef enum logic {
        TMR_IDLE,
        TMR_RUN
    } tmr_state_e;

    function automatic bit cfg_ok(input int audio_dw, input int num_ch, input int slot_w, input int sck_div);
        return (audio_dw > 0) && (num_ch > 0) && (slot_w >= audio_dw) &&
               (sck_div >= 4) && (sck_div % 2 == 0) && (num_ch % 2 == 0);
    endfunction

endpackage

// File: rtl/tdm_tx_master_if.sv
// rtl/tdm_tx_master_if.sv - whole-frame valid/ready handshake into the transmitter shadow buffer
interface tdm_tx_master_if #(
    parameter int DW = 16
);
    logic [DW-1:0] data_i;
    logic          valid_i;
    logic          ready_o;

    modport master (output data_i, output valid_i, input ready_o);
    modport slave  (input data_i, input valid_i, output ready_o);
endinterface

// File: rtl/tdm_bit_timer.sv
// rtl/tdm_bit_timer.sv - SCK divider, bit index and frame-load strobe for the TDM master
module tdm_bit_timer
    import audio_pkg::*;
#(
    parameter int SCK_DIV    = 16,
    parameter int FRAME_BITS = 32,
    localparam int K_W       = (FRAME_BITS > 1) ? $clog2(FRAME_BITS) : 1
) (
    input  logic           clk_i,
    input  logic           rst_i,
    input  logic           en_i,
    output logic           sck_o,
    output logic           tick_o,
    output logic           load_o,
    output logic [K_W-1:0] bit_nxt_o
);

    localparam int DIV_W = $clog2(SCK_DIV);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCK_DIV - 1);
    localparam logic [DIV_W-1:0] DIV_HALF = DIV_W'(SCK_DIV / 2);
    localparam logic [K_W-1:0]   K_LAST   = K_W'(FRAME_BITS - 1);

    tmr_state_e       state, state_nxt;
    logic [DIV_W-1:0] div_cnt, div_nxt;
    logic [K_W-1:0]   bit_cnt, bit_nxt;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state   <= TMR_IDLE;
            div_cnt <= '0;
            bit_cnt <= '0;
            sck_o   <= 1'b0;
        end else begin
            state   <= state_nxt;
            div_cnt <= div_nxt;
            bit_cnt <= bit_nxt;
            sck_o   <= (div_nxt >= DIV_HALF);
        end
    end

    // IDLE marks "no tick since enable": the first tick after enable always starts a frame at k=0
    always_comb begin
        state_nxt = state;
        div_nxt   = div_cnt;
        bit_nxt   = bit_cnt;
        tick_o    = 1'b0;
        load_o    = 1'b0;
        if (!en_i) begin
            state_nxt = TMR_IDLE;
            div_nxt   = '0;
            bit_nxt   = '0;
        end else if (div_cnt == DIV_LAST) begin
            div_nxt = '0;
            tick_o  = 1'b1;
            if (state == TMR_IDLE) begin
                state_nxt = TMR_RUN;
                bit_nxt   = '0;
                load_o    = 1'b1;
            end else if (bit_cnt == K_LAST) begin
                bit_nxt = '0;
                load_o  = 1'b1;
            end else begin
                bit_nxt = bit_cnt + K_W'(1);
            end
        end else begin
            div_nxt = div_cnt + DIV_W'(1);
        end
    end

    assign bit_nxt_o = bit_nxt;

endmodule

// File: rtl/tdm_tx_master.sv
// rtl/tdm_tx_master.sv - clock-master I2S/LJ/DSP serial audio transmitter with a one-frame shadow buffer
module tdm_tx_master
    import audio_pkg::*;
#(
    parameter int AUDIO_DW = 8,
    parameter int NUM_CH   = 2,
    parameter int SLOT_W   = 16,
    parameter int SCK_DIV  = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             en_i,
    input  logic [1:0]       fmt_i,
    tdm_tx_master_if.slave   s_if,
    output logic             sck_o,
    output logic             ws_o,
    output logic             sd_o,
    output logic             frame_start_o,
    output logic             underrun_o
);

    localparam int FW  = NUM_CH * SLOT_W;
    localparam int DW  = NUM_CH * AUDIO_DW;
    localparam int K_W = (FW > 1) ? $clog2(FW) : 1;
    localparam logic [K_W-1:0] WS_SPLIT = K_W'((NUM_CH / 2) * SLOT_W);

    if (!cfg_ok(AUDIO_DW, NUM_CH, SLOT_W, SCK_DIV)) begin : g_cfg_err
        $error("tdm_tx_master: illegal AUDIO_DW/NUM_CH/SLOT_W/SCK_DIV combination");
    end

    logic           tick, load;
    logic [K_W-1:0] bit_nxt;

    tdm_bit_timer #(
        .SCK_DIV    (SCK_DIV),
        .FRAME_BITS (FW)
    ) u_timer (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .en_i      (en_i),
        .sck_o     (sck_o),
        .tick_o    (tick),
        .load_o    (load),
        .bit_nxt_o (bit_nxt)
    );

    logic [DW-1:0] shadow;
    logic          shadow_full, full_nxt, accept;
    logic [FW-1:0] frame_fmt, shifter, shift_src;
    logic [1:0]    fmt_q, fmt_eff;
    logic          dly_bit, cur_bit, i2s_mode;

    assign accept   = s_if.valid_i & s_if.ready_o;
    // a load in the same clk as an accept sees the old (empty) shadow; the new data waits a frame
    assign full_nxt = accept | (shadow_full & ~load);

    always_comb begin
        frame_fmt = '0;
        for (int s = 0; s < NUM_CH; s++) begin
            for (int j = 0; j < AUDIO_DW; j++) begin
                frame_fmt[FW-1 - s*SLOT_W - j] = shadow[s*AUDIO_DW + AUDIO_DW-1 - j];
            end
        end
    end

    assign shift_src = load ? (shadow_full ? frame_fmt : '0) : shifter;
    assign cur_bit   = shift_src[FW-1];
    assign fmt_eff   = load ? fmt_i : fmt_q;
    assign i2s_mode  = (fmt_eff != FMT_LJ) && (fmt_eff != FMT_DSP);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            shadow        <= '0;
            shadow_full   <= 1'b0;
            s_if.ready_o  <= 1'b0;
            shifter       <= '0;
            fmt_q         <= FMT_I2S;
            dly_bit       <= 1'b0;
            ws_o          <= 1'b0;
            sd_o          <= 1'b0;
            frame_start_o <= 1'b0;
            underrun_o    <= 1'b0;
        end else begin
            frame_start_o <= load;
            underrun_o    <= load & ~shadow_full;
            shadow_full   <= full_nxt;
            s_if.ready_o  <= ~full_nxt;
            if (accept) begin
                shadow <= s_if.data_i;
            end
            if (!en_i) begin
                ws_o    <= 1'b0;
                sd_o    <= 1'b0;
                dly_bit <= 1'b0;
            end else if (tick) begin
                shifter <= shift_src << 1;
                dly_bit <= cur_bit;
                sd_o    <= i2s_mode ? dly_bit : cur_bit;
                ws_o    <= (fmt_eff == FMT_DSP) ? (bit_nxt == '0) : (bit_nxt >= WS_SPLIT);
                if (load) begin
                    fmt_q <= fmt_i;
                end
            end
        end
    end

endmodule

// File: tb/tb_tdm_tx_master.sv
// tb/tb_tdm_tx_master.sv - randomized bench for tdm_tx_master against a cycle-count reference model
`timescale 1ns/1ps
module tb_tdm_tx_master;
    import audio_pkg::*;

    localparam int A_DIV = 16;
    localparam int B_CH  = 4;
    localparam int B_SW  = 8;
    localparam int B_DIV = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic       en_a, en_b;
    logic [1:0] fmt_a, fmt_b;
    logic       sck_a, ws_a, sd_a, fs_a, ur_a;
    logic       sck_b, ws_b, sd_b, fs_b, ur_b;

    tdm_tx_master_if #(.DW(16)) if_a ();
    tdm_tx_master_if #(.DW(32)) if_b ();

    tdm_tx_master dut_a (
        .clk_i(clk), .rst_i(rst), .en_i(en_a), .fmt_i(fmt_a), .s_if(if_a),
        .sck_o(sck_a), .ws_o(ws_a), .sd_o(sd_a), .frame_start_o(fs_a), .underrun_o(ur_a)
    );

    tdm_tx_master #(.AUDIO_DW(8), .NUM_CH(B_CH), .SLOT_W(B_SW), .SCK_DIV(B_DIV)) dut_b (
        .clk_i(clk), .rst_i(rst), .en_i(en_b), .fmt_i(fmt_b), .s_if(if_b),
        .sck_o(sck_b), .ws_o(ws_b), .sd_o(sd_b), .frame_start_o(fs_b), .underrun_o(ur_b)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         n;
        int         k;
        bit         tick;
        bit         full;
        logic [31:0] shadow;
        logic [31:0] frame;
        logic [1:0] fmt_lat;
        bit         prev;
        bit         ready, sck, ws, sd, fs, ur;
    } mdl_t;

    mdl_t        ma, mb;
    int          n_chk, n_err, ur_cnt_a, lat;
    int          mode_a, mode_b;
    bit          cap_on_a, cap_on_b, hit, got_fs;
    logic [15:0] fix_a;
    logic [31:0] fix_b;
    logic [31:0] cap_sd_a, cap_ws_a, cap_sd_b, cap_ws_b;
    logic [31:0] exp_sd_a, exp_ws_a, exp_sd_b, exp_ws_b;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // n = clocks since enable; SCK tick every dv clocks, frame every nch*sw ticks
    task automatic mdl_step(inout mdl_t m, input int aw, input int nch, input int sw, input int dv,
                            input bit r, input bit e, input logic [1:0] f, input bit v, input logic [31:0] d);
        int fw, s, j;
        bit acc, b;
        fw     = nch * sw;
        acc    = v && m.ready;
        m.fs   = 0;
        m.ur   = 0;
        m.tick = 0;
        if (r) begin
            m.n = 0; m.k = 0; m.full = 0; m.shadow = '0; m.frame = '0; m.fmt_lat = FMT_I2S;
            m.prev = 0; m.ready = 0; m.sck = 0; m.ws = 0; m.sd = 0;
            return;
        end
        if (!e) begin
            m.n = 0; m.sck = 0; m.ws = 0; m.sd = 0; m.prev = 0;
        end else begin
            m.n++;
            m.sck = (m.n % dv) >= dv / 2;
            if (m.n % dv == 0) begin
                m.tick = 1;
                m.k = (m.n / dv - 1) % fw;
                if (m.k == 0) begin
                    m.fs = 1;
                    m.fmt_lat = f;
                    if (m.full) begin
                        m.frame = m.shadow;
                        m.full  = 0;
                    end else begin
                        m.frame = '0;
                        m.ur    = 1;
                    end
                end
                s = m.k / sw;
                j = m.k % sw;
                b = (j < aw) ? m.frame[s*aw + aw-1 - j] : 1'b0;
                m.ws = (m.fmt_lat == FMT_DSP) ? (m.k == 0) : (m.k >= fw / 2);
                m.sd = (m.fmt_lat == FMT_LJ || m.fmt_lat == FMT_DSP) ? b : m.prev;
                m.prev = b;
            end
        end
        if (acc) begin
            m.full   = 1;
            m.shadow = d;
        end
        m.ready = !m.full;
    endtask

    task automatic cycle();
        @(negedge clk);
        mdl_step(ma, 8, 2, 16, A_DIV, rst, en_a, fmt_a, if_a.valid_i, {16'h0, if_a.data_i});
        mdl_step(mb, 8, B_CH, B_SW, B_DIV, rst, en_b, fmt_b, if_b.valid_i, if_b.data_i);
        check("a_outs", {26'h0, if_a.ready_o, sck_a, ws_a, sd_a, fs_a, ur_a},
              {26'h0, ma.ready, ma.sck, ma.ws, ma.sd, ma.fs, ma.ur});
        check("b_outs", {26'h0, if_b.ready_o, sck_b, ws_b, sd_b, fs_b, ur_b},
              {26'h0, mb.ready, mb.sck, mb.ws, mb.sd, mb.fs, mb.ur});
        if (ur_a) ur_cnt_a++;
        if (ma.tick) begin
            cap_sd_a = {cap_sd_a[30:0], sd_a};
            cap_ws_a = {cap_ws_a[30:0], ws_a};
            if (cap_on_a && ma.k == 31) begin
                check("a_frame_sd", cap_sd_a, exp_sd_a);
                check("a_frame_ws", cap_ws_a, exp_ws_a);
            end
        end
        if (mb.tick) begin
            cap_sd_b = {cap_sd_b[30:0], sd_b};
            cap_ws_b = {cap_ws_b[30:0], ws_b};
            if (cap_on_b && mb.k == 31) begin
                check("b_frame_sd", cap_sd_b, exp_sd_b);
                check("b_frame_ws", cap_ws_b, exp_ws_b);
            end
        end
        case (mode_a)
            0: if_a.valid_i = 1'b0;
            1: begin if_a.valid_i = 1'b1; if_a.data_i = fix_a; end
            2: begin if_a.valid_i = ($urandom_range(0, 15) == 0); if_a.data_i = 16'($urandom); end
            default: ;
        endcase
        case (mode_b)
            0: if_b.valid_i = 1'b0;
            1: begin if_b.valid_i = 1'b1; if_b.data_i = fix_b; end
            2: begin if_b.valid_i = ($urandom_range(0, 7) == 0); if_b.data_i = $urandom; end
            default: ;
        endcase
    endtask

    initial begin
        rst = 1'b1; en_a = 1'b0; en_b = 1'b0; fmt_a = FMT_LJ; fmt_b = FMT_DSP;
        if_a.valid_i = 1'b0; if_a.data_i = '0; if_b.valid_i = 1'b0; if_b.data_i = '0;
        mode_a = 0; mode_b = 0; cap_on_a = 0; cap_on_b = 0;
        fix_a = 16'h3CA5; fix_b = 32'h78563412;
        exp_sd_a = 32'hA5003C00; exp_ws_a = 32'h0000FFFF;
        exp_sd_b = 32'h12345678; exp_ws_b = 32'h80000000;
        cap_sd_a = '0; cap_ws_a = '0; cap_sd_b = '0; cap_ws_b = '0;
        n_chk = 0; n_err = 0; ur_cnt_a = 0;

        repeat (4) cycle();
        check("rst_outs_a", {26'h0, if_a.ready_o, sck_a, ws_a, sd_a, fs_a, ur_a}, 32'h0);
        rst = 1'b0;
        cycle();
        check("ready_rise_a", {31'h0, if_a.ready_o}, 32'h1);
        check("ready_rise_b", {31'h0, if_b.ready_o}, 32'h1);

        // no source data: an underrun at every load
        en_a = 1'b1; en_b = 1'b1; ur_cnt_a = 0;
        repeat (1024) cycle();
        check("idle_underruns_a", ur_cnt_a, 32'd2);

        // LJ on a, DSP on b, fixed samples
        mode_a = 1; mode_b = 1;
        repeat (1100) cycle();
        cap_on_a = 1; cap_on_b = 1;
        repeat (1100) cycle();

        // I2S on a, LJ on b
        cap_on_a = 0; cap_on_b = 0;
        fmt_a = FMT_I2S; exp_sd_a = 32'h52801E00;
        fmt_b = FMT_LJ;  exp_ws_b = 32'h0000FFFF;
        repeat (1100) cycle();
        cap_on_a = 1; cap_on_b = 1;
        repeat (1100) cycle();

        // valid on the same clk as a load
        cap_on_a = 0; cap_on_b = 0; mode_a = 0;
        repeat (1100) cycle();
        hit = 0;
        for (int i = 0; i < 1200 && !hit; i++) begin
            cycle();
            if (!ma.full && ((ma.n + 1) % (A_DIV * 32)) == A_DIV) hit = 1;
        end
        check("coinc_found", {31'h0, hit}, 32'h1);
        mode_a = 3; if_a.valid_i = 1'b1; if_a.data_i = 16'hBEEF;
        cycle();
        check("coinc_underrun", {31'h0, ur_a}, 32'h1);
        check("coinc_ready", {31'h0, if_a.ready_o}, 32'h0);
        if_a.valid_i = 1'b0;
        repeat (600) cycle();

        // enable dropped mid-frame, shadow kept across the gap
        fmt_a = FMT_LJ; exp_sd_a = 32'hA5003C00; mode_a = 1;
        repeat (700) cycle();
        en_a = 1'b0;
        cycle();
        check("en_off_outs", {29'h0, sck_a, ws_a, sd_a}, 32'h0);
        repeat (50) cycle();
        en_a = 1'b1; cap_on_a = 1; lat = 0; got_fs = 0;
        for (int i = 0; i < 64 && !got_fs; i++) begin
            cycle();
            lat++;
            if (fs_a) got_fs = 1;
        end
        check("restart_latency", lat, A_DIV);
        repeat (1100) cycle();

        // random soak: data, formats, enables and resets
        cap_on_a = 0; cap_on_b = 0; mode_a = 2; mode_b = 2;
        for (int i = 0; i < 6000; i++) begin
            rst = ($urandom_range(0, 2999) == 0);
            if ($urandom_range(0, 699) == 0) en_a = ~en_a;
            if ($urandom_range(0, 499) == 0) en_b = ~en_b;
            if ($urandom_range(0, 299) == 0) fmt_a = 2'($urandom);
            if ($urandom_range(0, 199) == 0) fmt_b = 2'($urandom);
            cycle();
        end
        rst = 1'b0;
        cycle();

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
